// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encodings, opcodes,
// ALU op codes and the mux select codes that the datapath decodes identically.
package mc_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_IMM_EX   = 4'd9,
        S_IMM_WB   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_JR       = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic       IORD_PC     = 1'b0;
    localparam logic       IORD_ALUOUT = 1'b1;
    localparam logic [1:0] REGDST_RT   = 2'd0;
    localparam logic [1:0] REGDST_RD   = 2'd1;
    localparam logic [1:0] REGDST_RA   = 2'd2;
    localparam logic [1:0] MTR_ALUOUT  = 2'd0;
    localparam logic [1:0] MTR_MDR     = 2'd1;
    localparam logic [1:0] MTR_PC      = 2'd2;
    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_A      = 1'b1;
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMMSH  = 2'd3;
    localparam logic [1:0] PCSRC_ALU   = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP  = 2'd2;
    localparam logic [1:0] PCSRC_REG   = 2'd3;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       reg_wr;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_fsm_outdec.sv
// Combinational state -> control word decode. Every field defaults to 0 so no
// select is ever left undriven; pc_en/ir_wr here are unqualified requests.
module mc_ctrl_fsm_outdec
    import mc_ctrl_fsm_pkg::*;
(
    input  state_t     state,
    input  logic       imm_ori,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.iord    = IORD_PC;
                cw.mem_rd  = 1'b1;
                cw.ir_wr   = 1'b1;
                cw.pc_en   = 1'b1;
                cw.alusrca = SRCA_PC;
                cw.alusrcb = SRCB_FOUR;
                cw.alu_op  = ALU_ADD;
                cw.pcsrc   = PCSRC_ALU;
            end
            S_DECODE: begin
                cw.alusrca = SRCA_PC;
                cw.alusrcb = SRCB_IMMSH;
                cw.alu_op  = ALU_ADD;
            end
            S_MEMADR: begin
                cw.alusrca = SRCA_A;
                cw.alusrcb = SRCB_IMM;
                cw.alu_op  = ALU_ADD;
            end
            S_MEMRD: begin
                cw.iord   = IORD_ALUOUT;
                cw.mem_rd = 1'b1;
            end
            S_MEMWB: begin
                cw.regdst   = REGDST_RT;
                cw.memtoreg = MTR_MDR;
                cw.reg_wr   = 1'b1;
            end
            S_MEMWR: begin
                cw.iord   = IORD_ALUOUT;
                cw.mem_wr = 1'b1;
            end
            S_RTYPE_EX: begin
                cw.alusrca = SRCA_A;
                cw.alusrcb = SRCB_B;
                cw.alu_op  = ALU_FUNCT;
            end
            S_RTYPE_WB: begin
                cw.regdst   = REGDST_RD;
                cw.memtoreg = MTR_ALUOUT;
                cw.reg_wr   = 1'b1;
            end
            S_IMM_EX: begin
                cw.alusrca = SRCA_A;
                cw.alusrcb = SRCB_IMM;
                cw.alu_op  = imm_ori ? ALU_OR : ALU_ADD;
            end
            S_IMM_WB: begin
                cw.regdst = REGDST_RT;
                cw.reg_wr = 1'b1;
            end
            S_BRANCH: begin
                cw.alusrca = SRCA_A;
                cw.alusrcb = SRCB_B;
                cw.alu_op  = ALU_SUB;
                cw.pcsrc   = PCSRC_ALUOUT;
                cw.pc_en   = 1'b1;
            end
            S_JUMP: begin
                cw.pcsrc = PCSRC_JUMP;
                cw.pc_en = 1'b1;
            end
            // PC already holds PC+4 here, so the link value comes straight from PC.
            S_JAL: begin
                cw.regdst   = REGDST_RA;
                cw.memtoreg = MTR_PC;
                cw.reg_wr   = 1'b1;
                cw.pcsrc    = PCSRC_JUMP;
                cw.pc_en    = 1'b1;
            end
            S_JR: begin
                cw.pcsrc = PCSRC_REG;
                cw.pc_en = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: state register, dispatch and memory-ready stalls.
// Outputs are a Moore decode of the state, with FETCH/BRANCH pc_en qualified here.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int USE_MEM_READY = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               iord_sel,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               ir_wr,
    output logic [1:0]         regdst_sel,
    output logic [1:0]         memtoreg_sel,
    output logic               reg_wr,
    output logic               alusrca_sel,
    output logic [1:0]         alusrcb_sel,
    output logic [1:0]         pcsrc_sel,
    output logic [1:0]         alu_op,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t     cur;
    logic       is_sw, is_ori, is_bne;
    logic       rdy;
    state_t     disp;
    logic       illegal;
    logic       pc_gate;
    ctrl_word_t cw;

    assign rdy = (USE_MEM_READY == 0) ? 1'b1 : mem_ready;

    always_comb begin
        disp    = S_FETCH;
        illegal = 1'b0;
        case (opcode)
            OP_LW, OP_SW:    disp = S_MEMADR;
            OP_RTYPE:        disp = (funct == FN_JR) ? S_JR : S_RTYPE_EX;
            OP_BEQ, OP_BNE:  disp = S_BRANCH;
            OP_ADDI, OP_ORI: disp = S_IMM_EX;
            OP_J:            disp = S_JUMP;
            OP_JAL:          disp = S_JAL;
            default:         illegal = 1'b1;
        endcase
    end

    // Opcode-dependent flags are captured in DECODE; the IR is not re-read later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= S_IDLE;
            is_sw  <= 1'b0;
            is_ori <= 1'b0;
            is_bne <= 1'b0;
        end else begin
            case (cur)
                S_IDLE:   cur <= S_FETCH;
                S_FETCH:  if (rdy) cur <= S_DECODE;
                S_DECODE: begin
                    cur    <= disp;
                    is_sw  <= (opcode == OP_SW);
                    is_ori <= (opcode == OP_ORI);
                    is_bne <= (opcode == OP_BNE);
                end
                S_MEMADR:   cur <= is_sw ? S_MEMWR : S_MEMRD;
                S_MEMRD:    if (rdy) cur <= S_MEMWB;
                S_MEMWR:    if (rdy) cur <= S_FETCH;
                S_RTYPE_EX: cur <= S_RTYPE_WB;
                S_IMM_EX:   cur <= S_IMM_WB;
                S_MEMWB, S_RTYPE_WB, S_IMM_WB, S_BRANCH,
                S_JUMP, S_JAL, S_JR: cur <= S_FETCH;
                default:    cur <= S_IDLE;
            endcase
        end
    end

    mc_ctrl_fsm_outdec u_outdec (
        .state   (cur),
        .imm_ori (is_ori),
        .cw      (cw)
    );

    always_comb begin
        pc_gate = 1'b1;
        if (cur == S_FETCH)
            pc_gate = rdy;
        else if (cur == S_BRANCH)
            pc_gate = is_bne ? ~zero : zero;
    end

    assign pc_en        = cw.pc_en & pc_gate;
    assign ir_wr        = cw.ir_wr & rdy;
    assign iord_sel     = cw.iord;
    assign mem_rd       = cw.mem_rd;
    assign mem_wr       = cw.mem_wr;
    assign regdst_sel   = cw.regdst;
    assign memtoreg_sel = cw.memtoreg;
    assign reg_wr       = cw.reg_wr;
    assign alusrca_sel  = cw.alusrca;
    assign alusrcb_sel  = cw.alusrcb;
    assign pcsrc_sel    = cw.pcsrc;
    assign alu_op       = cw.alu_op;
    assign illegal_op   = (cur == S_DECODE) & illegal;
    assign state        = STATE_W'(cur);

endmodule
